// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: arbitrates memory stall, branch redirect and data-hazard stall,
// drives all stage stall/flush/bubble enables, counts stall/flush events and flags data-stall deadlock.
//
// state  | meaning
// RUN    | pipeline advancing normally (or squashing on a branch)
// DSTALL | front end held waiting on a forwarded IDC operand
// MSTALL | whole pipeline held while data memory is busy
module pipeline_ctrl #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PC_W           = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              no_forwarding_data,
  input  logic              branch_taken_EXB,
  input  logic [PC_W-1:0]   branch_target_EXB,
  input  logic              mem_busy,
  output logic              stall_IF,
  output logic              stall_IDC,
  output logic              stall_IDR,
  output logic              stall_EX,
  output logic              stall_MEM,
  output logic              bubble_EXB,
  output logic              bubble_WB,
  output logic              flush_IF,
  output logic              flush_IDC,
  output logic              flush_IDR,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              deadlock_err
);

  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] C_TIMEOUT    = DW'(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] C_TIMEOUT_M1 = DW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    MSTALL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pend_br;
  logic [PC_W-1:0]   r_pend_pc;
  logic              r_redirect_valid;
  logic [PC_W-1:0]   r_redirect_pc;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_deadlock_err;
  logic [DW-1:0]     r_dstall_run;

  logic              w_branch;
  logic              w_front_stall;

  assign w_branch = branch_taken_EXB | r_pend_br;

  always_comb begin
    w_state_nxt   = r_state;
    stall_IF      = 1'b0;
    stall_IDC     = 1'b0;
    stall_IDR     = 1'b0;
    stall_EX      = 1'b0;
    stall_MEM     = 1'b0;
    bubble_EXB    = 1'b0;
    bubble_WB     = 1'b0;
    flush_IF      = 1'b0;
    flush_IDC     = 1'b0;
    flush_IDR     = 1'b0;
    w_front_stall = 1'b0;
    if (rst) begin
      flush_IF    = 1'b1;
      flush_IDC   = 1'b1;
      flush_IDR   = 1'b1;
      w_state_nxt = RUN;
    end else if (mem_busy) begin
      stall_IF      = 1'b1;
      stall_IDC     = 1'b1;
      stall_IDR     = 1'b1;
      stall_EX      = 1'b1;
      stall_MEM     = 1'b1;
      bubble_WB     = 1'b1;
      w_front_stall = 1'b1;
      w_state_nxt   = MSTALL;
    end else if (w_branch) begin
      // The operand-starved consumer is younger than the branch and gets squashed.
      flush_IF    = 1'b1;
      flush_IDC   = 1'b1;
      flush_IDR   = 1'b1;
      w_state_nxt = RUN;
    end else if (no_forwarding_data) begin
      stall_IF      = 1'b1;
      stall_IDC     = 1'b1;
      stall_IDR     = 1'b1;
      bubble_EXB    = 1'b1;
      w_front_stall = 1'b1;
      w_state_nxt   = DSTALL;
    end else begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= RUN;
      r_pend_br        <= 1'b0;
      r_pend_pc        <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_stall_cnt      <= '0;
      r_flush_cnt      <= '0;
      r_deadlock_err   <= 1'b0;
      r_dstall_run     <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_redirect_valid <= 1'b0;
      if (w_front_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (mem_busy) begin
        // EXB is held, so the first captured branch is the only real one.
        if (branch_taken_EXB && !r_pend_br) begin
          r_pend_br <= 1'b1;
          r_pend_pc <= branch_target_EXB;
        end
      end else if (w_branch) begin
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= r_pend_br ? r_pend_pc : branch_target_EXB;
        r_pend_br        <= 1'b0;
        r_dstall_run     <= '0;
        if (r_flush_cnt != {CNT_W{1'b1}})
          r_flush_cnt <= r_flush_cnt + 1'b1;
      end else if (no_forwarding_data) begin
        if (r_dstall_run != C_TIMEOUT)
          r_dstall_run <= r_dstall_run + 1'b1;
        if (r_dstall_run >= C_TIMEOUT_M1)
          r_deadlock_err <= 1'b1;
      end else begin
        r_dstall_run <= '0;
      end
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;
  assign deadlock_err   = r_deadlock_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs driven on falling edges, combinational outputs
// checked 1ns later, registered outputs checked after the following rising edge.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 8;
  localparam int PC_W  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              nfd;
  logic              bt;
  logic [PC_W-1:0]   tgt;
  logic              mb;
  logic              stall_IF, stall_IDC, stall_IDR, stall_EX, stall_MEM;
  logic              bubble_EXB, bubble_WB;
  logic              flush_IF, flush_IDC, flush_IDR;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              deadlock_err;

  int checks   = 0;
  int failures = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .no_forwarding_data(nfd), .branch_taken_EXB(bt),
    .branch_target_EXB(tgt), .mem_busy(mb),
    .stall_IF(stall_IF), .stall_IDC(stall_IDC), .stall_IDR(stall_IDR),
    .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .bubble_EXB(bubble_EXB), .bubble_WB(bubble_WB),
    .flush_IF(flush_IF), .flush_IDC(flush_IDC), .flush_IDR(flush_IDR),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .deadlock_err(deadlock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs the ten stall/flush/bubble enables: {stall IF,IDC,IDR,EX,MEM, bubble EXB,WB, flush IF,IDC,IDR}
  function automatic logic [9:0] ctl();
    return {stall_IF, stall_IDC, stall_IDR, stall_EX, stall_MEM,
            bubble_EXB, bubble_WB, flush_IF, flush_IDC, flush_IDR};
  endfunction

  task automatic drive(input logic r, input logic n, input logic b, input logic [PC_W-1:0] t,
                       input logic m);
    @(negedge clk);
    rst = r; nfd = n; bt = b; tgt = t; mb = m;
    #1;
  endtask

  localparam logic [9:0] C_IDLE  = 10'b00000_00_000;
  localparam logic [9:0] C_FLUSH = 10'b00000_00_111;
  localparam logic [9:0] C_DSTL  = 10'b11100_10_000;
  localparam logic [9:0] C_MSTL  = 10'b11111_01_000;

  initial begin
    rst = 1'b1; nfd = 1'b0; bt = 1'b0; tgt = '0; mb = 1'b0;

    // reset state
    drive(1, 0, 0, 0, 0);
    chk("rst_ctl", ctl(), C_FLUSH);
    drive(1, 1, 1, 64'h55, 1);
    chk("rst_ctl_inputs_active", ctl(), C_FLUSH);
    drive(0, 0, 0, 0, 0);
    chk("rst_redirect", redirect_valid, 1'b0);
    chk("rst_pc", redirect_pc, 64'h0);
    chk("rst_stall_cnt", stall_cnt, 4'h0);
    chk("rst_flush_cnt", flush_cnt, 4'h0);
    chk("rst_deadlock", deadlock_err, 1'b0);
    chk("idle_ctl", ctl(), C_IDLE);

    // data stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      chk($sformatf("dstall_ctl_%0d", i), ctl(), C_DSTL);
    end
    drive(0, 0, 0, 0, 0);
    chk("dstall_cnt", stall_cnt, 4'h3);
    chk("dstall_release_ctl", ctl(), C_IDLE);

    // branch outranks a same-cycle data hazard
    drive(0, 1, 1, 64'h8000_0040, 0);
    chk("br_ctl", ctl(), C_FLUSH);
    chk("br_no_redirect_yet", redirect_valid, 1'b0);
    drive(0, 0, 0, 64'hFFFF, 0);
    chk("br_redirect", redirect_valid, 1'b1);
    chk("br_pc", redirect_pc, 64'h8000_0040);
    chk("br_flush_cnt", flush_cnt, 4'h1);
    chk("br_stall_cnt_unchanged", stall_cnt, 4'h3);
    drive(0, 0, 0, 0, 0);
    chk("br_pulse_end", redirect_valid, 1'b0);

    // back-to-back branches: two pulses, second target wins
    drive(0, 0, 1, 64'hA0, 0);
    drive(0, 0, 1, 64'hB0, 0);
    chk("b2b_first", {redirect_valid, redirect_pc}, {1'b1, 64'hA0});
    drive(0, 0, 0, 0, 0);
    chk("b2b_second", {redirect_valid, redirect_pc}, {1'b1, 64'hB0});
    chk("b2b_flush_cnt", flush_cnt, 4'h3);

    // memory stall cycles 0-4 with a branch arriving in cycle 1
    for (int c = 0; c < 5; c++) begin
      drive(0, c == 3, c == 1, (c == 1) ? 64'h100 : 64'h999, 1);
      chk($sformatf("mstall_ctl_%0d", c), ctl(), C_MSTL);
      chk($sformatf("mstall_no_redirect_%0d", c), redirect_valid, 1'b0);
    end
    drive(0, 0, 0, 64'h777, 0);
    chk("mstall_pend_flush", ctl(), C_FLUSH);
    drive(0, 0, 0, 0, 0);
    chk("mstall_redirect", {redirect_valid, redirect_pc}, {1'b1, 64'h100});
    chk("mstall_flush_cnt", flush_cnt, 4'h4);
    chk("mstall_stall_cnt", stall_cnt, 4'h8);
    chk("mstall_ctl_after", ctl(), C_IDLE);
    drive(0, 0, 0, 0, 0);
    chk("mstall_one_pulse", redirect_valid, 1'b0);

    // deadlock after TO consecutive data-stall cycles
    for (int i = 0; i < TO; i++) begin
      drive(0, 1, 0, 0, 0);
      if (i == TO - 1) chk("dl_not_yet", deadlock_err, 1'b0);
    end
    drive(0, 0, 0, 0, 0);
    chk("dl_set", deadlock_err, 1'b1);
    chk("stall_cnt_sat_a", stall_cnt, 4'hF);
    drive(0, 0, 0, 0, 0);
    chk("dl_sticky", deadlock_err, 1'b1);

    // reset while a branch is pending
    drive(0, 0, 1, 64'h200, 1);
    drive(1, 0, 0, 0, 1);
    chk("rst_mid_ctl", ctl(), C_FLUSH);
    drive(0, 0, 0, 0, 0);
    chk("rst_mid_redirect", redirect_valid, 1'b0);
    chk("rst_mid_ctl_after", ctl(), C_IDLE);
    chk("rst_mid_cnts", {stall_cnt, flush_cnt}, 8'h00);
    chk("rst_mid_deadlock", deadlock_err, 1'b0);
    drive(0, 0, 0, 0, 0);
    chk("rst_mid_no_late_redirect", redirect_valid, 1'b0);

    // a memory stall does not restart the data-stall run
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("dl_across_mstall", deadlock_err, 1'b1);
    chk("dl_across_cnt", stall_cnt, 4'h9);

    // saturation of a 4-bit counter over 20 stall cycles
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 0);
      if (i == 14) chk("sat_e", stall_cnt, 4'hE);
    end
    drive(0, 0, 0, 0, 0);
    chk("sat_f", stall_cnt, 4'hF);
    chk("sat_flush_cnt", flush_cnt, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
